// File: rtl/rf_wb_sched_if.sv
// Decode-issue, write-back and register-file write-port bundle for rf_wb_sched.
interface rf_wb_sched_if;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NUM_REGS = 32;

  // Decode issue
  logic                iss_valid;
  logic [REG_AW-1:0]   iss_rs1;
  logic [REG_AW-1:0]   iss_rs2;
  logic [REG_AW-1:0]   iss_rd;
  logic                iss_we;
  logic                iss_use_rs2;
  logic                iss_ready;

  // Short (fixed-latency) write-back, never back-pressured
  logic                s_wb_valid;
  logic [REG_AW-1:0]   s_wb_rd;
  logic [DATA_W-1:0]   s_wb_data;

  // Long (handshaked) write-back
  logic                l_wb_valid;
  logic [REG_AW-1:0]   l_wb_rd;
  logic [DATA_W-1:0]   l_wb_data;
  logic                l_wb_ready;

  // Register file write port and status
  logic                rf_we;
  logic [REG_AW-1:0]   rf_wr;
  logic [DATA_W-1:0]   rf_wd;
  logic [NUM_REGS-1:0] busy_vec;
  logic                wb_err;

  // Decode / execution side
  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_we, iss_use_rs2,
    output s_wb_valid, s_wb_rd, s_wb_data,
    output l_wb_valid, l_wb_rd, l_wb_data,
    input  iss_ready, l_wb_ready,
    input  rf_we, rf_wr, rf_wd, busy_vec, wb_err
  );

  // Scheduler side
  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_we, iss_use_rs2,
    input  s_wb_valid, s_wb_rd, s_wb_data,
    input  l_wb_valid, l_wb_rd, l_wb_data,
    output iss_ready, l_wb_ready,
    output rf_we, rf_wr, rf_wd, busy_vec, wb_err
  );

endinterface

// File: rtl/rf_wb_sched.sv
// Register-file write-back scheduler: issue scoreboard (RAW/WAW stall),
// fixed-priority write-port arbitration (short path first) and a
// starvation throttle that stops issue while a long write-back waits.
module rf_wb_sched #(
  parameter int unsigned STARVE_LIM = 4
) (
  input logic          clk,
  input logic          rst_n,
  rf_wb_sched_if.slave bus
);

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned CNT_W    = 3;

  localparam logic [CNT_W-1:0] WAIT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WAIT_TRIP = CNT_W'(STARVE_LIM - 1);

  localparam logic [0:0] NORMAL   = 1'b0;
  localparam logic [0:0] THROTTLE = 1'b1;

  // State
  logic [0:0]          state_q;
  logic [0:0]          state_d;
  logic [CNT_W-1:0]    wait_q;
  logic [CNT_W-1:0]    wait_d;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                rf_we_q;
  logic                rf_we_d;
  logic [REG_AW-1:0]   rf_wr_q;
  logic [REG_AW-1:0]   rf_wr_d;
  logic [DATA_W-1:0]   rf_wd_q;
  logic [DATA_W-1:0]   rf_wd_d;
  logic                err_q;
  logic                err_d;

  // Combinational decisions
  logic                iss_ready_c;
  logic                iss_acc_c;
  logic                l_ready_c;
  logic                l_acc_c;
  logic                l_blocked_c;
  logic                win_valid_c;
  logic [REG_AW-1:0]   win_rd_c;
  logic [DATA_W-1:0]   win_data_c;
  logic                src1_hz_c;
  logic                src2_hz_c;
  logic                dst_hz_c;

  // Hazard detection against the scoreboard; x0 is never busy
  always_comb begin
    src1_hz_c   = 1'b0;
    src2_hz_c   = 1'b0;
    dst_hz_c    = 1'b0;
    iss_ready_c = 1'b0;
    src1_hz_c   = busy_q[bus.iss_rs1];
    src2_hz_c   = bus.iss_use_rs2 && busy_q[bus.iss_rs2];
    dst_hz_c    = bus.iss_we && busy_q[bus.iss_rd];
    iss_ready_c = rst_n && (state_q != THROTTLE) &&
                  !src1_hz_c && !src2_hz_c && !dst_hz_c;
  end

  assign iss_acc_c = bus.iss_valid && iss_ready_c;

  // Write-port arbitration: short path always wins when present
  always_comb begin
    l_ready_c   = 1'b0;
    l_acc_c     = 1'b0;
    l_blocked_c = 1'b0;
    win_valid_c = 1'b0;
    win_rd_c    = '0;
    win_data_c  = '0;
    l_ready_c   = rst_n && !bus.s_wb_valid;
    l_acc_c     = bus.l_wb_valid && l_ready_c;
    l_blocked_c = bus.l_wb_valid && !l_ready_c;
    if (bus.s_wb_valid) begin
      win_valid_c = 1'b1;
      win_rd_c    = bus.s_wb_rd;
      win_data_c  = bus.s_wb_data;
    end else if (l_acc_c) begin
      win_valid_c = 1'b1;
      win_rd_c    = bus.l_wb_rd;
      win_data_c  = bus.l_wb_data;
    end
  end

  // Next write-port values; address/data hold when nothing wins
  always_comb begin
    rf_we_d = 1'b0;
    rf_wr_d = rf_wr_q;
    rf_wd_d = rf_wd_q;
    if (win_valid_c) begin
      rf_we_d = (win_rd_c != '0);
      rf_wr_d = win_rd_c;
      rf_wd_d = win_data_c;
    end
  end

  // Scoreboard update: retire on the write cycle, then set on issue (set wins)
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_wr_q] = 1'b0;
    end
    if (iss_acc_c && bus.iss_we && (bus.iss_rd != '0)) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Sticky error: a write-back arrived for a register with nothing in flight
  always_comb begin
    err_d = err_q;
    if (win_valid_c && (win_rd_c != '0) && !busy_q[win_rd_c]) begin
      err_d = 1'b1;
    end
  end

  // Starvation FSM next state and blocked-cycle counter
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    if (l_blocked_c) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + CNT_W'(1);
    end
    case (state_q)
      NORMAL: begin
        if (l_blocked_c && (wait_q >= WAIT_TRIP)) begin
          state_d = THROTTLE;
        end
      end
      THROTTLE: begin
        if (!l_blocked_c) begin
          state_d = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= NORMAL;
      wait_q  <= '0;
      busy_q  <= '0;
      rf_we_q <= 1'b0;
      rf_wr_q <= '0;
      rf_wd_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      rf_we_q <= rf_we_d;
      rf_wr_q <= rf_wr_d;
      rf_wd_q <= rf_wd_d;
      err_q   <= err_d;
    end
  end

  // Output drive
  assign bus.iss_ready  = iss_ready_c;
  assign bus.l_wb_ready = l_ready_c;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_wr      = rf_wr_q;
  assign bus.rf_wd      = rf_wd_q;
  assign bus.busy_vec   = busy_q;
  assign bus.wb_err     = err_q;

endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Register-file write-back scheduler and issue scoreboard for the decode stage. It tracks which architectural registers have a result in flight and stalls decode issue on RAW or WAW hazards. It also arbitrates the register file's single write port between the fixed-latency ALU/short path and a handshaked long-latency path (loads, multiply), and drives the registered write port (we / write address / write data) of the register file.

## Interface
Parameters:
- `STARVE_LIM`, default 4: consecutive cycles a long write-back may wait before issue is throttled.

Ports (one clock; reset is synchronous and active-low):
- `clk` input, 1: clock, all state on rising edge.
- `rst_n` input, 1: synchronous active-low reset.
- `iss_valid` input, 1: decode presents an instruction.
- `iss_rs1`, `iss_rs2` input, 5 each: source registers.
- `iss_rd` input, 5: destination register.
- `iss_we` input, 1: instruction writes `iss_rd`.
- `iss_use_rs2` input, 1: `iss_rs2` is a real operand.
- `iss_ready` output, 1: issue accepted when `iss_valid && iss_ready`.
- `s_wb_valid` input, 1: short-path result. No back-pressure; always accepted.
- `s_wb_rd` input, 5: short-path destination.
- `s_wb_data` input, 32: short-path result data.
- `l_wb_valid` input, 1: long-path result.
- `l_wb_rd` input, 5: long-path destination.
- `l_wb_data` input, 32: long-path result data.
- `l_wb_ready` output, 1: long-path handshake.
- `rf_we` output, 1: register file write enable (registered).
- `rf_wr` output, 5: register file write address (registered).
- `rf_wd` output, 32: register file write data (registered).
- `busy_vec` output, 32: per-register pending flag; bit 0 is always 0.
- `wb_err` output, 1: sticky; a write-back targeted a non-busy register.

## Operation
Scoreboard:
- `busy_vec[r]` is set on issue accept when `iss_we` is high and `iss_rd` is not 0.
- `busy_vec[r]` is cleared at the end of a cycle in which `rf_we` is high and `rf_wr` equals r.
- Set and clear of the same register in the same cycle: set wins. This cannot occur legally.

Issue readiness:
- `iss_ready` is 1 only when all of the following hold:
  - `rst_n` is high;
  - the state is not THROTTLE;
  - `busy_vec[iss_rs1]` is 0;
  - `busy_vec[iss_rs2]` is 0, or `iss_use_rs2` is 0;
  - `busy_vec[iss_rd]` is 0, or `iss_we` is 0.
- Register x0 is never busy.
- `iss_ready` is combinational on the current inputs and state.

Write-port arbitration (fixed priority):
- The short path has priority.
- `l_wb_ready` equals `rst_n && !s_wb_valid`.
- The winner is registered into `rf_we`/`rf_wr`/`rf_wd` at the next edge.
- A write-back with rd equal to 0 is accepted, but the next-cycle `rf_we` is 0.
- When there is no winner, `rf_we` is 0 and `rf_wr`/`rf_wd` hold their previous values.
- `wb_err` is set when an accepted write-back has a non-zero rd and `busy_vec[rd]` is 0. It clears only on reset.

Starvation state machine (states NORMAL and THROTTLE):
- `wait_cnt`, 3 bits, increments each cycle in which `l_wb_valid && !l_wb_ready`. It is cleared on any cycle where the long path is accepted or `l_wb_valid` is 0.
- NORMAL goes to THROTTLE when `wait_cnt` reaches `STARVE_LIM-1` and the long path is still blocked.
- In THROTTLE, `iss_ready` is 0, so issue stops and the short path drains.
- THROTTLE goes to NORMAL in the cycle after the long write-back is accepted, or when `l_wb_valid` drops.

Reset (`rst_n` low at a clock edge):
- `busy_vec` = 0, `rf_we` = 0, `rf_wr` = 0, `rf_wd` = 0, `wb_err` = 0, state = NORMAL, `wait_cnt` = 0.
- `iss_ready` and `l_wb_ready` are 0 while `rst_n` is low.
- Reset mid-operation discards all in-flight scoreboard state.

## Timing
Write-back to register file:
- Write-back accepted in cycle N → `rf_we` high in cycle N+1 → register file written and busy bit cleared at the end of N+1.
- A dependent issue is first ready in cycle N+2. There is no same-cycle bypass.

Issue to busy:
- Issue accepted in cycle N → `busy_vec[rd]` high from N+1.
- Two back-to-back issues are allowed if they are independent.

Long path under contention:
- With `s_wb_valid` held high continuously, the long path waits at most `STARVE_LIM` cycles plus the short-path drain time.
- The long path's handshake is accepted on `l_wb_valid && l_wb_ready`. Its data must be held stable until accepted.

## Test plan
- **Reset:** hold `rst_n` low 2 cycles with all inputs toggling → all outputs 0; then issue rd=5 → `busy_vec` = 0x20 next cycle.
- **RAW stall:** issue rd=3, then rs1=3 → `iss_ready` = 0. Short write-back rd=3 in cycle N → `rf_we`=1, `rf_wr`=3 in N+1; `iss_ready`=1 in N+2.
- **Arbitration:** `s_wb` (rd=4, 0xAAAA) and `l_wb` (rd=6, 0x5555) valid in the same cycle → `l_wb_ready`=0; register file receives 4/0xAAAA, then 6/0x5555 one cycle later.
- **Starvation:** `s_wb_valid` held 1 with `l_wb_valid`=1 for 4 cycles → THROTTLE with `iss_ready`=0. Drop `s_wb_valid` → long write-back accepted; state returns to NORMAL the next cycle.
- **x0 and WAW:** issue rd=0 → `busy_vec` unchanged; write-back rd=0 → `rf_we`=0. Issue rd=7 twice → second issue stalled until 7 retires.
- **Error:** write-back to rd=9 while not busy → `wb_err`=1 sticky until reset.
